// File: rtl/axi_ddr_bridge.sv
// Serialises upstream AXI4 bursts into single-outstanding DDR bursts of at most MAX_BURST beats.
// Latency: first d_axvalid one cycle after the upstream address handshake; R/W data pass through combinationally.
// Backpressure: every ready/valid pair stalls indefinitely; payloads stay stable while a valid is held.
module axi_ddr_bridge #(
    parameter int         DATA_WIDTH = 32,
    parameter int         MAX_BURST  = 16,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic                    s_bvalid,
    output logic [1:0]              s_bresp,
    input  logic                    s_bready,
    input  logic [31:0]             s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    s_rvalid,
    output logic                    s_rlast,
    input  logic                    s_rready,
    output logic [3:0]              d_awid,
    output logic [31:0]             d_awaddr,
    output logic [7:0]              d_awlen,
    output logic [2:0]              d_awsize,
    output logic [1:0]              d_awburst,
    output logic                    d_awvalid,
    input  logic                    d_awready,
    output logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_wlast,
    output logic                    d_wvalid,
    input  logic                    d_wready,
    input  logic                    d_bvalid,
    input  logic [1:0]              d_bresp,
    output logic                    d_bready,
    output logic [3:0]              d_arid,
    output logic [31:0]             d_araddr,
    output logic [7:0]              d_arlen,
    output logic [2:0]              d_arsize,
    output logic [1:0]              d_arburst,
    output logic                    d_arvalid,
    input  logic                    d_arready,
    input  logic [DATA_WIDTH-1:0]   d_rdata,
    input  logic [1:0]              d_rresp,
    input  logic                    d_rlast,
    input  logic                    d_rvalid,
    output logic                    d_rready
);
    localparam logic [2:0] AXSIZE    = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RESP_UP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [8:0]  remaining;
    logic [8:0]  cur_len;
    logic [8:0]  beat_cnt;
    logic        err;

    logic [8:0]  chunk;
    logic        last_beat, aw_acc, ar_acc, ax_hs, r_hs, w_hs, r_end;
    logic        unused;

    assign unused    = ^{s_wlast, d_rresp, d_bresp[0]};
    assign chunk     = (remaining > MAX_BEATS) ? MAX_BEATS : remaining;
    assign last_beat = (beat_cnt == cur_len - 9'd1);
    assign aw_acc    = (state == IDLE) && s_awvalid;
    assign ar_acc    = (state == IDLE) && s_arvalid && !s_awvalid;
    assign ax_hs     = ((state == WR_ADDR) && d_awready) || ((state == RD_ADDR) && d_arready);
    assign r_hs      = (state == RD_DATA) && d_rvalid && s_rready;
    assign w_hs      = (state == WR_DATA) && s_wvalid && d_wready;
    // A short DDR burst (early d_rlast) still closes the chunk.
    assign r_end     = last_beat || d_rlast;

    // Upstream ready is gated by reset so it cannot echo s_axvalid while reset is held.
    assign s_awready = aw_acc && reset_n;
    assign s_arready = ar_acc && reset_n;

    assign d_awid    = AXI_ID;
    assign d_arid    = AXI_ID;
    assign d_awsize  = AXSIZE;
    assign d_arsize  = AXSIZE;
    assign d_awburst = 2'b01;
    assign d_arburst = 2'b01;
    assign d_awaddr  = addr;
    assign d_araddr  = addr;
    assign d_awlen   = 8'(chunk - 9'd1);
    assign d_arlen   = 8'(chunk - 9'd1);
    assign d_awvalid = (state == WR_ADDR);
    assign d_arvalid = (state == RD_ADDR);

    assign s_rdata   = d_rdata;
    assign s_rvalid  = (state == RD_DATA) && d_rvalid;
    assign d_rready  = (state == RD_DATA) && s_rready;
    assign s_rlast   = (state == RD_DATA) && d_rvalid && r_end && (remaining == 9'd0);

    assign d_wdata   = s_wdata;
    assign d_wstrb   = s_wstrb;
    assign d_wvalid  = (state == WR_DATA) && s_wvalid;
    assign s_wready  = (state == WR_DATA) && d_wready;
    assign d_wlast   = (state == WR_DATA) && last_beat;

    assign d_bready  = (state == WR_RESP);
    assign s_bvalid  = (state == RESP_UP);
    assign s_bresp   = ((state == RESP_UP) && err) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (aw_acc)      state_nxt = WR_ADDR;
                else if (ar_acc) state_nxt = RD_ADDR;
            end
            RD_ADDR: if (d_arready) state_nxt = RD_DATA;
            RD_DATA: if (r_hs && r_end) state_nxt = (remaining != 9'd0) ? RD_ADDR : IDLE;
            WR_ADDR: if (d_awready) state_nxt = WR_DATA;
            WR_DATA: if (w_hs && last_beat) state_nxt = WR_RESP;
            WR_RESP: if (d_bvalid) state_nxt = (remaining != 9'd0) ? WR_ADDR : RESP_UP;
            RESP_UP: if (s_bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // remaining/addr already point past the current chunk once its address is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= 32'd0;
            remaining <= 9'd0;
            cur_len   <= 9'd0;
            beat_cnt  <= 9'd0;
            err       <= 1'b0;
        end else begin
            if (aw_acc) begin
                addr      <= s_awaddr;
                remaining <= {1'b0, s_awlen} + 9'd1;
            end else if (ar_acc) begin
                addr      <= s_araddr;
                remaining <= {1'b0, s_arlen} + 9'd1;
            end
            if (ax_hs) begin
                addr      <= addr + (32'(chunk) << AXSIZE);
                remaining <= remaining - chunk;
                cur_len   <= chunk;
                beat_cnt  <= 9'd0;
            end else if (r_hs || w_hs) begin
                beat_cnt  <= beat_cnt + 9'd1;
            end
            if ((state == WR_RESP) && d_bvalid) begin
                err <= err | d_bresp[1];
            end else if ((state == RESP_UP) && s_bready) begin
                err <= 1'b0;
            end
        end
    end
endmodule
